// File: rtl/dcc_pkg.sv
// rtl/dcc_pkg.sv - shared arbiter state type, region field width and index helpers
package dcc_pkg;

  localparam int REG_FW = 6;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_REQ     = 2'd1,
    ARB_GRANT   = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + step) mod n, valid for base < n and step < n
  function automatic int wrap_inc(input int base, input int step, input int n);
    int s;
    s = base + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/dcc_rr_pick.sv
// rtl/dcc_rr_pick.sv - first active request found searching upward from a start index, wrapping
module dcc_rr_pick import dcc_pkg::*; #(
  parameter int  NREQ = 2,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'(wrap_inc(int'(start), k, NREQ));
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcc_arb.sv
// rtl/dcc_arb.sv - bus arbiter with CS0 region decode, wait-state generator and FRT capture pulses
module dcc_arb import dcc_pkg::*; #(
  parameter int  NREQ = 2,
  parameter int  NREG = 4,
  parameter int  WSW  = 4,
  parameter int  RR   = 1,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE_R,
  input  logic [NREQ-1:0]        BREQ_N,
  output logic [NREQ-1:0]        BACK_N,
  output logic                   BRLS_N,
  input  logic                   BGR_N,
  input  logic [24:1]            A,
  input  logic                   CS0_N,
  input  logic                   RD_N,
  input  logic [1:0]             WE_N,
  input  logic                   WTIN_N,
  output logic                   WAIT_N,
  input  logic [NREG*REG_FW-1:0] REG_BASE,
  input  logic [NREG*REG_FW-1:0] REG_MASK,
  input  logic [NREG*WSW-1:0]    REG_WS,
  output logic [NREG-1:0]        RCE_N,
  output logic                   MFTI,
  output logic                   SFTI
);

  arb_state_t    state, state_nx;
  logic [IW-1:0] own, own_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [IW-1:0] pick_idx, pick_start;
  logic          pick_valid;
  logic          own_req;

  assign pick_start = (RR != 0) ? ptr : '0;
  assign own_req    = ~BREQ_N[own];

  dcc_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (~BREQ_N),
    .start (pick_start),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ARB_IDLE;
      own   <= '0;
      ptr   <= '0;
    end else if (CE_R) begin
      state <= state_nx;
      own   <= own_nx;
      ptr   <= ptr_nx;
    end
  end

  // Owner is fixed from the IDLE->REQ decision until the bus goes back to IDLE.
  always_comb begin
    state_nx = state;
    own_nx   = own;
    ptr_nx   = ptr;
    BRLS_N   = 1'b1;
    BACK_N   = '1;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_nx = ARB_REQ;
          own_nx   = pick_idx;
        end
      end
      ARB_REQ: begin
        BRLS_N = 1'b0;
        if (!own_req) begin
          state_nx = ARB_RELEASE;
        end else if (!BGR_N) begin
          state_nx = ARB_GRANT;
          ptr_nx   = IW'(wrap_inc(int'(own), 1, NREQ));
        end
      end
      ARB_GRANT: begin
        BRLS_N      = 1'b0;
        BACK_N[own] = 1'b0;
        if (!own_req) state_nx = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        if (BGR_N) state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  logic [REG_FW-1:0] a_hi;
  logic [NREG-1:0]   hit;
  logic [WSW-1:0]    ws_sel;

  assign a_hi  = A[24:19];
  assign RCE_N = ~hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NREG; i++) begin
      hit[i] = !CS0_N &&
               (((a_hi ^ REG_BASE[i*REG_FW +: REG_FW]) & REG_MASK[i*REG_FW +: REG_FW]) == '0);
    end
  end

  // Descending scan so the lowest-index hit region is the one that sticks.
  always_comb begin
    ws_sel = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) ws_sel = REG_WS[i*WSW +: WSW];
    end
  end

  logic           strobe, strobe_q;
  logic           start, strobe_rise, is_write;
  logic [WSW-1:0] wcnt;

  assign strobe      = RD_N & (&WE_N);
  assign start       = !strobe && strobe_q && !CS0_N;
  assign strobe_rise = strobe && !strobe_q;
  assign is_write    = ~&WE_N;

  always_ff @(posedge CLK) begin
    if (RST) begin
      strobe_q <= 1'b1;
      wcnt     <= '0;
      MFTI     <= 1'b1;
      SFTI     <= 1'b1;
    end else if (CE_R) begin
      strobe_q <= strobe;
      if (strobe_rise)
        wcnt <= '0;
      else if (start)
        wcnt <= ws_sel;
      else if (wcnt != '0)
        wcnt <= wcnt - WSW'(1);
      MFTI <= !(start && is_write && (A[24:23] == 2'b11));
      SFTI <= !(start && is_write && (A[24:23] == 2'b10));
    end
  end

  assign WAIT_N = WTIN_N & (RST | (wcnt == '0));

endmodule
